// File: rtl/ssd_scan_driver_pkg.sv
// Shared definitions for the seven-segment scan driver: FSM states,
// active-high gfedcba segment patterns and a power-of-ten helper.
package ssd_scan_driver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Segment patterns, active-high, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // 10^n, used for the overflow limit at elaboration time
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/ssd_scan_driver_seg7_decode.sv
// BCD nibble to active-high seven-segment pattern with blank and dash overrides.
module seg7_decode
  import ssd_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  // Dash wins over blank; non-decimal nibbles show nothing
  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (!blank) begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment driver: sequential double-dabble binary-to-BCD
// conversion, free-running digit refresh, leading-zero blanking, per-digit
// decimal points and overflow dashes.
module ssd_scan_driver
  import ssd_scan_driver_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned VALUE_W     = 13,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  busy,
  output logic                  ovf,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int unsigned     BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned     CNT_W = $clog2(VALUE_W + 1);
  localparam int unsigned     PRE_W = $clog2(REFRESH_DIV);
  localparam int unsigned     IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam longint unsigned LIMIT = pow10(NUM_DIGITS);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(VALUE_W - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  state_t                  state, state_next;
  logic [VALUE_W-1:0]      bin;
  logic [BCD_W-1:0]        bcd, bcd_adj, display;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    ovf_pend;
  logic [PRE_W-1:0]        presc;
  logic [IDX_W-1:0]        idx;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [3:0]              nibble;
  logic                    digit_blank;
  logic [6:0]              seg_raw;

  // Conversion state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: one SHIFT cycle per input bit, then a DONE cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = SHIFT;
      SHIFT:   if (bit_cnt == LAST_BIT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Conversion datapath; display and ovf only change in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin      <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      ovf_pend <= 1'b0;
      display  <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            bin      <= value;
            bcd      <= '0;
            bit_cnt  <= '0;
            ovf_pend <= (64'(value) >= LIMIT);
          end
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          bit_cnt    <= bit_cnt + 1'b1;
        end
        DONE: begin
          display <= bcd;
          ovf     <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

  // Refresh prescaler and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRE_LAST) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Current digit selection and leading-zero detection
  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
    nibble      = display[4*idx +: 4];
    digit_blank = blank_lz && (idx != '0) && ((display >> (4*idx)) == '0);
  end

  seg7_decode u_decode (
    .nibble (nibble),
    .blank  (digit_blank),
    .dash   (ovf),
    .seg    (seg_raw)
  );

  // Registered output stage with polarity applied
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode <= {NUM_DIGITS{ACTIVE_LOW}};
      seg   <= {7{ACTIVE_LOW}};
      dp    <= ACTIVE_LOW;
    end else begin
      anode <= onehot ^ {NUM_DIGITS{ACTIVE_LOW}};
      seg   <= seg_raw ^ {7{ACTIVE_LOW}};
      dp    <= dp_mask[idx] ^ ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver: a cycle-level arithmetic model
// compared every cycle, plus directed literal expectations.
module tb_ssd_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned VW = 14;
  localparam int unsigned RD = 4;

  logic          clk;
  logic          rst;
  logic [VW-1:0] value;
  logic          load;
  logic          blank_lz;
  logic [ND-1:0] dp_mask;
  logic          busy, ovf, dp;
  logic [ND-1:0] anode;
  logic [6:0]    seg;

  int errors = 0;
  int checks = 0;
  bit started = 0;

  ssd_scan_driver #(
    .NUM_DIGITS  (ND),
    .VALUE_W     (VW),
    .REFRESH_DIV (RD),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .load     (load),
    .blank_lz (blank_lz),
    .dp_mask  (dp_mask),
    .busy     (busy),
    .ovf      (ovf),
    .anode    (anode),
    .seg      (seg),
    .dp       (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Active-low digit patterns, hand-derived
  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic int unsigned p10(input int unsigned k);
    int unsigned r = 1;
    for (int unsigned i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  // Model: edge count since reset determines the lit digit; an accepted
  // load makes the result visible VW+1 edges later.
  int unsigned m_n, m_cnt, m_disp, m_pend, m_k;
  bit          m_ovf;
  logic        e_busy, e_ovf, e_dp;
  logic [3:0]  e_anode;
  logic [6:0]  e_seg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n = 0; m_cnt = 0; m_disp = 0; m_pend = 0; m_ovf = 0;
      e_anode = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_busy = 1'b0; e_ovf = 1'b0;
    end else begin
      m_k = (m_n / RD) % ND;
      e_anode = 4'hF;
      e_anode[m_k] = 1'b0;
      if (m_ovf) e_seg = 7'h3F;
      else if (blank_lz && m_k > 0 && m_disp < p10(m_k)) e_seg = 7'h7F;
      else e_seg = seg_tbl[(m_disp / p10(m_k)) % 10];
      e_dp = ~dp_mask[m_k];
      m_n++;
      if (m_cnt == 0) begin
        if (load) begin
          m_cnt  = VW + 1;
          m_pend = value;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_ovf  = (m_pend >= p10(ND));
          m_disp = m_pend;
        end
      end
      e_busy = (m_cnt != 0);
      e_ovf  = m_ovf;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      check("busy",  busy,  e_busy);
      check("ovf",   ovf,   e_ovf);
      check("anode", anode, e_anode);
      check("seg",   seg,   e_seg);
      check("dp",    dp,    e_dp);
    end
  end

  task automatic do_load(input int unsigned v);
    @(negedge clk);
    value = VW'(v);
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic wait_anode(input string nm, input logic [3:0] an);
    int n = 0;
    while (anode !== an && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_reach"}, anode, an);
  endtask

  task automatic show(input string nm, input logic [3:0] an, input logic [6:0] s);
    wait_anode(nm, an);
    check(nm, seg, s);
  endtask

  task automatic hold_len(input string nm, output int h);
    logic [3:0] cur;
    cur = anode;
    h = 0;
    while (anode === cur && h < 50) begin
      @(negedge clk);
      h++;
    end
    check(nm, h, 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b0; load = 1'b0; value = '0; blank_lz = 1'b0; dp_mask = 4'b0100;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    started = 1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rel_anode", anode, 4'b1110);
    check("rst_rel_seg",   seg,   7'b1000000);

    // Latency and digit order for 1234
    do_load(1234);
    wait_idle(n);
    check("busy_len_1234", n, VW + 1);
    show("d0_4", 4'b1110, 7'b0011001);
    show("d1_3", 4'b1101, 7'b0110000);
    show("d2_2", 4'b1011, 7'b0100100);
    show("d3_1", 4'b0111, 7'b1111001);

    // Load while busy is dropped and does not extend busy
    do_load(4321);
    n = 0;
    while (busy && n < 200) begin
      load  = (n == 3);
      value = VW'(5555);
      @(negedge clk);
      n++;
    end
    load = 1'b0;
    check("busy_len_ignored", n, VW + 1);
    @(negedge clk);
    show("ign_d0_1", 4'b1110, 7'b1111001);
    show("ign_d3_4", 4'b0111, 7'b0011001);

    // Refresh order, hold time and decimal point
    wait_anode("sync0", 4'b0111);
    wait_anode("sync1", 4'b1110);
    hold_len("hold_0", n);
    check("order_1", anode, 4'b1101);
    hold_len("hold_1", n);
    check("order_2", anode, 4'b1011);
    check("dp_on_2", dp, 1'b0);
    hold_len("hold_2", n);
    check("order_3", anode, 4'b0111);
    check("dp_off_3", dp, 1'b1);
    hold_len("hold_3", n);
    check("order_wrap", anode, 4'b1110);

    // Leading-zero blanking
    blank_lz = 1'b1;
    do_load(7);
    wait_idle(n);
    show("lz_d0_7", 4'b1110, 7'b1111000);
    show("lz_d1_blank", 4'b1101, 7'h7F);
    show("lz_d3_blank", 4'b0111, 7'h7F);
    blank_lz = 1'b0;
    @(negedge clk);
    show("nolz_d3_0", 4'b0111, 7'b1000000);
    blank_lz = 1'b1;
    do_load(0);
    wait_idle(n);
    show("zero_d0", 4'b1110, 7'b1000000);
    show("zero_d2_blank", 4'b1011, 7'h7F);

    // Overflow shows dashes regardless of blanking, clears on in-range value
    do_load(10000);
    wait_idle(n);
    check("ovf_set", ovf, 1'b1);
    show("ovf_d2_dash", 4'b1011, 7'b0111111);
    show("ovf_d0_dash", 4'b1110, 7'b0111111);
    do_load(16383);
    wait_idle(n);
    check("ovf_max", ovf, 1'b1);
    do_load(9999);
    wait_idle(n);
    check("ovf_clr", ovf, 1'b0);
    show("d3_9", 4'b0111, 7'b0010000);
    show("d0_9", 4'b1110, 7'b0010000);
    blank_lz = 1'b0;

    // Reset in the middle of a conversion
    do_load(10000);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_anode", anode, 4'b1111);
    check("mid_rst_seg",   seg,   7'h7F);
    check("mid_rst_dp",    dp,    1'b1);
    check("mid_rst_busy",  busy,  1'b0);
    check("mid_rst_ovf",   ovf,   1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_anode", anode, 4'b1110);
    check("post_rst_seg",   seg,   7'b1000000);
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
